alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Multi-cycle execute controller that sequences the 16-bit ALU for register-register and register-immediate instructions.
- Accepts one decoded instruction per valid/ready handshake, reads operands from the external synchronous register file, and drives the ALU opcode and operands.
- Registers the ALU result, writes it back, and maintains the 5-bit processor status (PSR) flag register with per-opcode flag masking.
- Sits between instruction decode and the register file/ALU pair.

Parameters:
- DATA_W, 16, operand/result width.
- RA_W, 4, register-file address width (16 registers).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  decoded instruction present.
- instr_ready  out  1  controller can accept an instruction.
- opcode  in  5  ALU operation: ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, NOT=6, LSH=7, RSH=8, ARSH=9.
- rdest_idx  in  RA_W  destination register, also the Rdest operand.
- rsrc_idx  in  RA_W  source register.
- use_imm  in  1  1 = imm replaces the Rsrc operand.
- imm  in  DATA_W  immediate operand.
- rf_raddr_a  out  RA_W  register-file read address for Rdest.
- rf_raddr_b  out  RA_W  register-file read address for Rsrc.
- rf_rdata_a  in  DATA_W  register-file read data A (1-cycle synchronous read).
- rf_rdata_b  in  DATA_W  register-file read data B.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RA_W  write address.
- rf_wdata  out  DATA_W  write data.
- alu_opcode  out  5  to ALU OpCode.
- alu_rdest  out  DATA_W  to ALU Rdest.
- alu_rsrc  out  DATA_W  to ALU Rsrc.
- alu_out  in  DATA_W  ALU result.
- alu_flags  in  5  ALU flags; bit order [0]C [1]L [2]F [3]Z [4]N.
- psr  out  5  architectural flag register, same bit order.
- psr_clr  in  1  synchronous clear of psr.
- done  out  1  one-cycle pulse when the instruction retires.
- err  out  1  one-cycle pulse when an illegal opcode retires.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions, except that reset forces IDLE from any state.
- IDLE: instr_ready=1. On instr_valid & instr_ready (cycle T), latch opcode, indices, use_imm and imm, then go to READ.
- Inputs are ignored when instr_ready=0. A held instr_valid is next accepted at T+4.
- READ (T+1): rf_raddr_a=rdest_idx, rf_raddr_b=rsrc_idx, held stable from READ through EXEC.
- EXEC (T+2):
  - alu_opcode=latched opcode; alu_rdest=rf_rdata_a; alu_rsrc = use_imm ? imm : rf_rdata_b.
  - alu_out and alu_flags are captured into internal registers at the end of the cycle.
  - Outside EXEC, alu_opcode=0 and alu_rdest/alu_rsrc=0.
- WB (T+3):
  - done=1.
  - rf_we=1 with rf_waddr=rdest_idx and rf_wdata=captured result, for opcodes 0,1,3-9 only. CMP and illegal opcodes produce no write.
  - PSR update is visible at T+4 and depends on the opcode:
    - ADD/SUB: update C and F only.
    - CMP: update L, Z and N only.
    - Logic and shift ops: no flag change.
  - Bits not updated hold their value. Captured x flag bits are never loaded into psr.
  - Opcodes 10-31 are illegal: err=1 with done, no rf write, psr unchanged.
- Latency: 4 cycles accept-to-done. Throughput: 1 instruction per 4 cycles.
- Write-back completes before the next READ, so no forwarding is required.
- psr_clr: clears psr to 0 at the next edge in any state. If it coincides with a WB flag update, the clear wins.
- Reset (async, any state):
  - state=IDLE; psr=0; rf_we=0; done=0; err=0; busy=0; instr_ready=1 after release.
  - All address, data and ALU-drive outputs go to 0.
  - An in-flight instruction is discarded with no write and no flag update.
- Arithmetic: the result is truncated to DATA_W. SUB is rdest - rsrc (ALU computes rdest + ~rsrc + 1), so C=1 means no borrow.

Test Plan:
- ADD with R1=0x7FFF, R2=0x0001, rdest=1, rsrc=2 -> rf_we at T+3 with waddr=1, wdata=0x8000; psr C=0, F=1; L/Z/N unchanged; done at T+3.
- SUB with R3=0x0005, use_imm=1, imm=0x0005 -> wdata=0x0000; psr C=1, F=0; no read-data B dependency.
- CMP with R5=0x0001, R6=0xFFFF -> no rf_we; psr L=1, Z=0, N=0; C/F retain the prior ADD values.
- opcode=12 -> err and done pulse at T+3; rf_we=0; psr unchanged; next instruction accepted normally.
- instr_valid held high with two instructions -> second accepted exactly at T+4; instr_ready=0 for T+1..T+3.
- reset asserted during EXEC, then an XOR instruction; separately, psr_clr coinciding with a WB of ADD:
  - Reset case: no rf_we, psr=0, instr_ready=1 after release; the following XOR executes correctly.
  - psr_clr case: psr=0.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Four-state execute sequencer (IDLE/READ/EXEC/WB) that feeds the 16-bit ALU from a
// synchronous register file, writes the result back and keeps the masked PSR flags.
module alu_exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        opcode,
  input  logic [RA_W-1:0]   rdest_idx,
  input  logic [RA_W-1:0]   rsrc_idx,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  output logic [RA_W-1:0]   rf_raddr_a,
  output logic [RA_W-1:0]   rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_rdest,
  output logic [DATA_W-1:0] alu_rsrc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr,
  input  logic              psr_clr,
  output logic              done,
  output logic              err,
  output logic              busy
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_CMP  = 5'd2;
  localparam logic [4:0] OP_LAST = 5'd9;
  // PSR bit order: [0]C [1]L [2]F [3]Z [4]N
  localparam logic [4:0] MASK_ARITH = 5'b00101;
  localparam logic [4:0] MASK_CMP   = 5'b11010;

  state_t              r_state, w_next;
  logic [4:0]          r_op;
  logic [RA_W-1:0]     r_rd, r_rs;
  logic                r_use_imm;
  logic [DATA_W-1:0]   r_imm, r_res;
  logic [4:0]          r_flg, r_psr;
  logic                w_accept, w_legal;
  logic [4:0]          w_mask;

  assign w_accept = instr_valid && (r_state == S_IDLE);
  assign w_legal  = (r_op <= OP_LAST);
  assign psr      = r_psr;

  always_comb begin
    w_mask = 5'b0;
    if (w_legal) begin
      if (r_op == OP_ADD || r_op == OP_SUB) w_mask = MASK_ARITH;
      else if (r_op == OP_CMP)              w_mask = MASK_CMP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_use_imm <= 1'b0;
      r_imm     <= '0;
      r_res     <= '0;
      r_flg     <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= opcode;
        r_rd      <= rdest_idx;
        r_rs      <= rsrc_idx;
        r_use_imm <= use_imm;
        r_imm     <= imm;
      end
      if (r_state == S_EXEC) begin
        r_res <= alu_out;
        r_flg <= alu_flags;
      end
    end
  end

  // Only masked bits are loaded, so unused (possibly undefined) ALU flags never reach psr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_psr <= '0;
    else if (psr_clr)           r_psr <= '0;
    else if (r_state == S_WB)   r_psr <= (r_psr & ~w_mask) | (r_flg & w_mask);
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_opcode  = '0;
    alu_rdest   = '0;
    alu_rsrc    = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) w_next = S_READ;
      end
      S_READ: begin
        rf_raddr_a = r_rd;
        rf_raddr_b = r_rs;
        w_next     = S_EXEC;
      end
      S_EXEC: begin
        rf_raddr_a = r_rd;
        rf_raddr_b = r_rs;
        alu_opcode = r_op;
        alu_rdest  = rf_rdata_a;
        alu_rsrc   = r_use_imm ? r_imm : rf_rdata_b;
        w_next     = S_WB;
      end
      S_WB: begin
        done     = 1'b1;
        err      = !w_legal;
        rf_we    = w_legal && (r_op != OP_CMP);
        rf_waddr = r_rd;
        rf_wdata = r_res;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
